// File: rtl/fme_pkg.sv
// fme_pkg: shared types, candidate offset tables and cost-width helper
// for the fractional motion-estimation refinement engine.
package fme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACC,
    S_CMP,
    S_DONE
  } state_t;

  typedef enum logic {
    P_HALF,
    P_QPEL
  } pass_t;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } ofs_t;

  localparam int N_HALF = 9;
  localparam int N_QPEL = 8;

  function automatic int cost_w(int pix_w, int blk_pix);
    return pix_w + $clog2(blk_pix);
  endfunction

  // Centre first, then the 8 half-pel neighbours in raster order.
  function automatic ofs_t half_ofs(logic [3:0] idx);
    ofs_t o;
    o = '0;
    unique case (idx)
      4'd0: o = '{dx: 3'sd0, dy: 3'sd0};
      4'd1: o = '{dx: -3'sd2, dy: -3'sd2};
      4'd2: o = '{dx: 3'sd0, dy: -3'sd2};
      4'd3: o = '{dx: 3'sd2, dy: -3'sd2};
      4'd4: o = '{dx: -3'sd2, dy: 3'sd0};
      4'd5: o = '{dx: 3'sd2, dy: 3'sd0};
      4'd6: o = '{dx: -3'sd2, dy: 3'sd2};
      4'd7: o = '{dx: 3'sd0, dy: 3'sd2};
      4'd8: o = '{dx: 3'sd2, dy: 3'sd2};
      default: o = '0;
    endcase
    return o;
  endfunction

  // Quarter-pel ring around the half-pel winner; centre is skipped.
  function automatic ofs_t qpel_ofs(logic [2:0] idx);
    ofs_t o;
    o = '0;
    unique case (idx)
      3'd0: o = '{dx: -3'sd1, dy: -3'sd1};
      3'd1: o = '{dx: 3'sd0, dy: -3'sd1};
      3'd2: o = '{dx: 3'sd1, dy: -3'sd1};
      3'd3: o = '{dx: -3'sd1, dy: 3'sd0};
      3'd4: o = '{dx: 3'sd1, dy: 3'sd0};
      3'd5: o = '{dx: -3'sd1, dy: 3'sd1};
      3'd6: o = '{dx: 3'sd0, dy: 3'sd1};
      3'd7: o = '{dx: 3'sd1, dy: 3'sd1};
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sad_acc.sv
// sad_acc: accumulates |a-b| per enabled beat; clr/rst zero the sum.
// Ports: clk, rst, clr, en, a, b (pixels) -> sum (COST_W).
module sad_acc #(
  parameter int PIX_W  = 8,
  parameter int COST_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [PIX_W-1:0]  a,
  input  logic [PIX_W-1:0]  b,
  output logic [COST_W-1:0] sum
);

  logic [PIX_W-1:0] diff;

  assign diff = (a > b) ? (a - b) : (b - a);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + {{(COST_W-PIX_W){1'b0}}, diff};
    end
  end

endmodule

// File: rtl/fme_refine.sv
// fme_refine: half-pel then optional quarter-pel SAD refinement FSM.
// Ports: start/qpel_en/mv_*_in in; req_* to interpolator; pix_* stream
// in; done, mv_*_out (quarter-pel), best_cost out; busy status.
module fme_refine
  import fme_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int BLK_PIX = 16,
  parameter int MV_W    = 8,
  parameter int COST_W  = cost_w(PIX_W, BLK_PIX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   qpel_en,
  input  logic signed [MV_W-1:0] mv_x_in,
  input  logic signed [MV_W-1:0] mv_y_in,
  output logic                   busy,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic signed [2:0]      req_dx,
  output logic signed [2:0]      req_dy,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [PIX_W-1:0]       cur_pix,
  input  logic [PIX_W-1:0]       ref_pix,
  output logic                   done,
  output logic signed [MV_W+1:0] mv_x_out,
  output logic signed [MV_W+1:0] mv_y_out,
  output logic [COST_W-1:0]      best_cost
);

  localparam int CNT_W = $clog2(BLK_PIX);

  state_t                state_q, state_d;
  pass_t                 pass_q;
  logic [3:0]            idx_q;
  logic [CNT_W-1:0]      beat_q;
  logic                  qpel_q;
  logic signed [MV_W-1:0] mvx_q, mvy_q;
  ofs_t                  ctr_q, best_q, best_nx;
  ofs_t                  cand, q_ofs;
  logic [COST_W-1:0]     best_cost_q, cost_nx, acc_sum;
  logic                  take, last_half, last_qpel, beat_last;
  logic                  more;
  logic signed [MV_W+1:0] res_x, res_y;

  sad_acc #(
    .PIX_W (PIX_W),
    .COST_W(COST_W)
  ) u_sad (
    .clk(clk),
    .rst(rst),
    .clr((state_q == S_REQ) && req_ready),
    .en ((state_q == S_ACC) && pix_valid),
    .a  (cur_pix),
    .b  (ref_pix),
    .sum(acc_sum)
  );

  always_comb begin
    q_ofs = qpel_ofs(idx_q[2:0]);
    if (pass_q == P_HALF) begin
      cand = half_ofs(idx_q);
    end else begin
      cand.dx = ctr_q.dx + q_ofs.dx;
      cand.dy = ctr_q.dy + q_ofs.dy;
    end
  end

  // First half candidate seeds the tracker; later ones need strict <.
  assign take = ((pass_q == P_HALF) && (idx_q == 4'd0))
              || (acc_sum < best_cost_q);
  assign best_nx = take ? cand : best_q;
  assign cost_nx = take ? acc_sum : best_cost_q;

  assign last_half = idx_q == 4'(N_HALF - 1);
  assign last_qpel = idx_q == 4'(N_QPEL - 1);
  assign beat_last = beat_q == CNT_W'(BLK_PIX - 1);
  assign more = (pass_q == P_HALF) ? (!last_half || qpel_q)
                                   : !last_qpel;

  assign res_x = {mvx_q, 2'b00}
               + {{(MV_W-1){best_nx.dx[2]}}, best_nx.dx};
  assign res_y = {mvy_q, 2'b00}
               + {{(MV_W-1){best_nx.dy[2]}}, best_nx.dy};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (req_ready) state_d = S_ACC;
      S_ACC:  if (pix_valid && beat_last) state_d = S_CMP;
      S_CMP:  state_d = more ? S_REQ : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    req_valid = 1'b0;
    pix_ready = 1'b0;
    done      = 1'b0;
    req_dx    = '0;
    req_dy    = '0;
    unique case (1'b1)
      (state_q == S_IDLE): ;
      (state_q == S_REQ): begin
        busy      = 1'b1;
        req_valid = 1'b1;
        req_dx    = cand.dx;
        req_dy    = cand.dy;
      end
      (state_q == S_ACC): begin
        busy      = 1'b1;
        pix_ready = 1'b1;
      end
      (state_q == S_CMP): busy = 1'b1;
      (state_q == S_DONE): begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q      <= P_HALF;
      idx_q       <= '0;
      beat_q      <= '0;
      qpel_q      <= 1'b0;
      mvx_q       <= '0;
      mvy_q       <= '0;
      ctr_q       <= '0;
      best_q      <= '0;
      best_cost_q <= '0;
      mv_x_out    <= '0;
      mv_y_out    <= '0;
      best_cost   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            qpel_q <= qpel_en;
            mvx_q  <= mv_x_in;
            mvy_q  <= mv_y_in;
            pass_q <= P_HALF;
            idx_q  <= '0;
          end
        end
        S_REQ: if (req_ready) beat_q <= '0;
        S_ACC: if (pix_valid) beat_q <= beat_q + 1'b1;
        S_CMP: begin
          best_q      <= best_nx;
          best_cost_q <= cost_nx;
          if ((pass_q == P_HALF) && last_half) begin
            pass_q <= P_QPEL;
            idx_q  <= '0;
            ctr_q  <= best_nx;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
          // Results land with the done pulse and hold until the next one.
          if (state_d == S_DONE) begin
            mv_x_out  <= res_x;
            mv_y_out  <= res_y;
            best_cost <= cost_nx;
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fme_refine.md
# fme_refine

Parametrised fractional-motion-estimation refinement engine: takes an integer-pel MV, runs a 9-candidate half-pel search, then optionally an 8-candidate quarter-pel search around the best half-pel point. Each candidate is scored by SAD over a streamed block of (current, reference) pixel pairs. It supplies the sequencing state machine that the existing FME top lacks. It sits between the integer ME stage and the external half/quarter interpolator, which serves the candidate requests.

## Interface
- PIX_W, 8, pixel width
- BLK_PIX, 16, pixel pairs per candidate (≥2)
- MV_W, 8, signed integer-pel MV width
- COST_W, PIX_W+$clog2(BLK_PIX), SAD width (exact, no overflow)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch search; sampled only in IDLE
- qpel_en  in  1  enable quarter pass; latched with start
- mv_x_in, mv_y_in  in  MV_W  signed integer-pel MV; latched with start
- busy  out  1  high from the cycle after start until done
- req_valid  out  1  candidate request
- req_ready  in  1  interpolator accepts request
- req_dx, req_dy  out  3  signed quarter-pel offset from integer MV (−3..+3)
- pix_valid  in  1  pixel pair valid
- pix_ready  out  1  high only in ACC
- cur_pix, ref_pix  in  PIX_W  unsigned pixel pair
- done  out  1  one-cycle completion pulse
- mv_x_out, mv_y_out  out  MV_W+2  signed quarter-pel result; held until next done
- best_cost  out  COST_W  SAD of result; held until next done

## Operation
- States: IDLE, REQ, ACC, CMP, DONE.
- IDLE: on start, latch inputs and go to REQ with pass=HALF, idx=0.
- Half pass order (dx,dy): (0,0) first, then raster (−2,−2),(0,−2),(+2,−2),(−2,0),(+2,0),(−2,+2),(0,+2),(+2,+2).
- Quarter pass: around best half offset (hx,hy); raster (hx−1,hy−1)…(hx+1,hy+1), skipping the centre. Centre cost is reused from the half pass, not re-fetched.
- REQ: req_valid=1 with offset. On req_valid&req_ready go to ACC and clear the accumulator. req_valid/offset stay stable until accepted.
- ACC: pix_ready=1. Each pix_valid beat adds |cur_pix−ref_pix|. After BLK_PIX beats go to CMP.
- CMP: replace the best if cost < best (strict), so the earlier candidate wins ties and the centre wins when all are equal. Then:
  - more candidates in the pass → REQ;
  - half pass finished and qpel_en → quarter pass → REQ;
  - otherwise → DONE.
- DONE: done=1; mv_out=(mv_in<<<2)+best offset; best_cost registered; → IDLE.
- start while busy is ignored. qpel_en/mv_in changes mid-search have no effect.

## Timing
- Reset: state=IDLE; busy, req_valid, pix_ready, done=0; req_dx/dy, mv_*_out, best_cost=0. In-flight beats are dropped. Interpolator must treat rst as an abort.
- Zero stalls: start sampled at cycle 0, REQ at cycle 1, each candidate costs BLK_PIX+2 cycles (REQ 1, ACC BLK_PIX, CMP 1).
- done cycle: 1+9·(BLK_PIX+2) without quarter pass; 1+17·(BLK_PIX+2) with it.
- Every req_ready-low or pix_valid-low cycle extends latency by exactly one cycle.
- busy falls the cycle after done. start may be reasserted in that same cycle (IDLE).
- pix_valid outside ACC is ignored, not consumed.

## Structure
- fme_pkg: state enum; half-pass offset LUT; quarter-pass raster LUT; cost_w() function.
- Sub-module sad_acc: |a−b| accumulator with clear/enable, COST_W output.
- fme_refine: FSM, candidate index/pass counters, best tracker, MV arithmetic.

## Test plan
- All pixels 100/100, qpel_en=1, mv_in=(3,−2) → cost 0; mv_out=(12,−8); done at cycle 307 (BLK_PIX=16).
- Half candidate (+2,−2) diff 1/pixel (cost 16), others diff 5 (cost 80), qpel_en=0, mv_in=(1,1) → mv_out=(6,2); best_cost=16; done at cycle 163.
- Same as above with qpel_en=1 and quarter (+3,−1) cost 8 → mv_out=(7,3); best_cost=8; centre never re-requested (8 quarter requests observed).
- Tie: candidates (−2,0) and (+2,0) both cost 10, rest 50 → (−2,0) chosen.
- Random stalls on req_ready/pix_valid (3-cycle gaps) → same result as no-stall run; latency extended by exact stall count.
- cur=255, ref=0 everywhere → best_cost=4080. Reset asserted mid-ACC → all outputs 0 next cycle; next start completes normally.
